// File: rtl/div_const_pipe_if.sv
// rtl/div_const_pipe_if.sv - operand/result stream bundle for div_const_pipe (out_qr with DIVC_ROUND_EN)
interface div_const_pipe_if #(
    parameter int WIDTH = 32,
    parameter int RW    = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [RW-1:0]    out_r;
`ifdef DIVC_ROUND_EN
    logic [WIDTH-1:0] out_qr;
`endif

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_q, out_r
`ifdef DIVC_ROUND_EN
        , input out_qr
`endif
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_q, out_r
`ifdef DIVC_ROUND_EN
        , output out_qr
`endif
    );
endinterface

// File: rtl/div_const_pipe.sv
// rtl/div_const_pipe.sv - pipelined unsigned divide-by-constant, one CHUNK-bit digit per stage
// DIVC_ROUND_EN adds the registered, saturating rounded quotient out_qr.
module div_const_pipe #(
    parameter int WIDTH   = 32,
    parameter int DIVISOR = 3,
    parameter int CHUNK   = 6
) (
    input logic             clk,
    input logic             rst_n,
    div_const_pipe_if.slave bus
);
    localparam int NSTG = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW   = NSTG * CHUNK;
    localparam int RW   = $clog2(DIVISOR);
    localparam int TW   = RW + CHUNK;
    localparam int TN   = 1 << TW;

    // Elaboration-time table: t = {r, digit} -> {t / DIVISOR, t % DIVISOR}
    logic [CHUNK-1:0] lut_q [TN];
    logic [RW-1:0]    lut_r [TN];

    for (genvar t = 0; t < TN; t++) begin : g_lut
        assign lut_q[t] = CHUNK'(t / DIVISOR);
        assign lut_r[t] = RW'(t % DIVISOR);
    end

    logic             vld_q [NSTG];
    logic [PW-1:0]    x_q   [NSTG];
    logic [RW-1:0]    rem_q [NSTG];
    logic [WIDTH-1:0] quo_q [NSTG];
    logic [RW-1:0]    rem_d [NSTG];
    logic [WIDTH-1:0] quo_d [NSTG];

    logic             out_valid_q;
    logic [WIDTH-1:0] out_q_q;
    logic [RW-1:0]    out_r_q;
    logic             adv;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_q    = out_q_q;
    assign bus.out_r    = out_r_q;

    // Partial quotient kept at WIDTH bits: the bits shifted out are provably zero.
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            rem_d[k] = lut_r[{rem_q[k], x_q[k][PW-1-k*CHUNK -: CHUNK]}];
            quo_d[k] = (quo_q[k] << CHUNK)
                     | WIDTH'(lut_q[{rem_q[k], x_q[k][PW-1-k*CHUNK -: CHUNK]}]);
        end
    end

`ifdef DIVC_ROUND_EN
    localparam logic [RW:0] DIV_W = (RW + 1)'(DIVISOR);

    logic [WIDTH-1:0] out_qr_q;
    logic [WIDTH-1:0] qr_d;
    logic             round_up;

    always_comb begin
        round_up = ({rem_d[NSTG-1], 1'b0} >= DIV_W);
        qr_d     = quo_d[NSTG-1] + WIDTH'(round_up && !(&quo_d[NSTG-1]));
    end

    assign bus.out_qr = out_qr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_qr_q <= '0;
        end else if (adv) begin
            out_qr_q <= qr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_q[k] <= 1'b0;
                x_q[k]   <= '0;
                rem_q[k] <= '0;
                quo_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            out_r_q     <= '0;
        end else if (adv) begin
            vld_q[0] <= bus.in_valid;
            x_q[0]   <= PW'(bus.in_x);
            rem_q[0] <= '0;
            quo_q[0] <= '0;
            for (int k = 1; k < NSTG; k++) begin
                vld_q[k] <= vld_q[k-1];
                x_q[k]   <= x_q[k-1];
                rem_q[k] <= rem_d[k-1];
                quo_q[k] <= quo_d[k-1];
            end
            out_valid_q <= vld_q[NSTG-1];
            out_q_q     <= quo_d[NSTG-1];
            out_r_q     <= rem_d[NSTG-1];
        end
    end
endmodule

// File: tb/tb_div_const_pipe.sv
// tb/tb_div_const_pipe.sv - scoreboard bench for div_const_pipe (default and 16/7/4 instances)
module tb_div_const_pipe;
    localparam int W    = 32;
    localparam int D    = 3;
    localparam int C    = 6;
    localparam int NST  = 6;
    localparam int W2   = 16;
    localparam int D2   = 7;
    localparam int C2   = 4;
    localparam int NST2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_const_pipe_if #(.WIDTH(W),  .RW(2)) bus  ();
    div_const_pipe_if #(.WIDTH(W2), .RW(3)) bus2 ();

    div_const_pipe #(.WIDTH(W), .DIVISOR(D), .CHUNK(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    div_const_pipe #(.WIDTH(W2), .DIVISOR(D2), .CHUNK(C2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic [63:0] qr;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic res_t model(input logic [63:0] x, input logic [63:0] d);
        res_t m;
        m.q  = x / d;
        m.r  = x % d;
        m.qr = m.q + (((m.r * 2) >= d) ? 64'd1 : 64'd0);
        if (m.qr > 64'hFFFF_FFFF) m.qr = 64'hFFFF_FFFF;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.in_x = '0;  bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_x = '0; bus2.out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_q !== '0 || bus.out_r !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%0b q=%0h r=%0h required 0 0 0",
                     bus.out_valid, bus.out_q, bus.out_r);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus2.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready in_ready=%0b dut2_valid=%0b required 1 0",
                     bus.in_ready, bus2.out_valid);
        end
    endtask

    task automatic test_single();
        int lat = 0;
        bit seen = 1'b0;
        bus.in_x = 32'd100;
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_accept in_ready=%0b required 1", bus.in_ready);
        end
        sb.push_back(model(64'd100, D));
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            lat++;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || lat != NST) begin
            errors++;
            $display("FAIL single_latency seen=%0b latency=%0d required %0d", seen, lat, NST);
        end
        checks++;
        if (sb.size() == 0 || 64'(bus.out_q) !== sb[0].q || 64'(bus.out_r) !== sb[0].r) begin
            errors++;
            $display("FAIL single_value q=%0d r=%0d required 33 1", bus.out_q, bus.out_r);
        end
        if (sb.size() > 0) void'(sb.pop_front());
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse out_valid=%0b required 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0};
        int sent = 0;
        int got = 0;
        int last_cyc = -1;
        for (int cyc = 0; cyc < 40 && (sent < 3 || sb.size() > 0); cyc++) begin
            if (sent < 3) begin
                bus.in_valid = 1'b1;
                bus.in_x = ops[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0 || 64'(bus.out_q) !== sb[0].q || 64'(bus.out_r) !== sb[0].r) begin
                    errors++;
                    $display("FAIL b2b_value idx=%0d q=%0h r=%0d required q=%0h r=%0d",
                             got, bus.out_q, bus.out_r, sb[0].q, sb[0].r);
                end
                if (got > 0) begin
                    checks++;
                    if (cyc != last_cyc + 1) begin
                        errors++;
                        $display("FAIL b2b_spacing idx=%0d cycle=%0d required %0d", got, cyc, last_cyc + 1);
                    end
                end
                last_cyc = cyc;
                got++;
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                sb.push_back(model(64'(bus.in_x), D));
                sent++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL b2b_count results=%0d required 3", got);
        end
    endtask

    task automatic test_stall();
        int sent = 0;
        int got = 0;
        bit stalled = 1'b0;
        logic [31:0] hq;
        logic [1:0]  hr;
        for (int cyc = 0; cyc < 100 && (sent < 8 || sb.size() > 0); cyc++) begin
            if (!stalled && bus.out_valid === 1'b1) begin
                stalled = 1'b1;
                bus.out_ready = 1'b0;
                hq = bus.out_q;
                hr = bus.out_r;
                for (int s = 0; s < 10; s++) begin
                    #1;
                    checks++;
                    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                        bus.out_q !== hq || bus.out_r !== hr) begin
                        errors++;
                        $display("FAIL stall_hold cycle=%0d in_ready=%0b valid=%0b q=%0h r=%0d required 0 1 %0h %0d",
                                 s, bus.in_ready, bus.out_valid, bus.out_q, bus.out_r, hq, hr);
                    end
                    tick();
                end
                bus.out_ready = 1'b1;
            end
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.in_x = $urandom();
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0 || 64'(bus.out_q) !== sb[0].q || 64'(bus.out_r) !== sb[0].r) begin
                    errors++;
                    $display("FAIL stall_value idx=%0d q=%0h r=%0d required q=%0h r=%0d",
                             got, bus.out_q, bus.out_r, sb[0].q, sb[0].r);
                end
                got++;
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                sb.push_back(model(64'(bus.in_x), D));
                sent++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 8 || !stalled) begin
            errors++;
            $display("FAIL stall_count results=%0d stalled=%0b required 8 1", got, stalled);
        end
    endtask

    task automatic test_reset_flight();
        bit leak = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x = $urandom();
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flight_reset out_valid=%0b required 0", bus.out_valid);
        end
        for (int i = 0; i < NST + 2; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) leak = 1'b1;
        end
        checks++;
        if (leak) begin
            errors++;
            $display("FAIL flight_stale stale_result=%0b required 0", leak);
        end
    endtask

    task automatic test_w16();
        int lat = 0;
        bit seen = 1'b0;
        res_t e;
        e = model(64'hFFFF, D2);
        bus2.in_x = 16'hFFFF;
        bus2.in_valid = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            lat++;
            if (bus2.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || lat != NST2) begin
            errors++;
            $display("FAIL w16_latency seen=%0b latency=%0d required %0d", seen, lat, NST2);
        end
        checks++;
        if (64'(bus2.out_q) !== e.q || 64'(bus2.out_r) !== e.r || bus2.out_q !== 16'd9362) begin
            errors++;
            $display("FAIL w16_value q=%0d r=%0d required 9362 1", bus2.out_q, bus2.out_r);
        end
    endtask

`ifdef DIVC_ROUND_EN
    task automatic test_round();
        logic [31:0] ops [2] = '{32'd5, 32'd4};
        int sent = 0;
        int got = 0;
        for (int cyc = 0; cyc < 40 && (sent < 2 || sb.size() > 0); cyc++) begin
            if (sent < 2) begin
                bus.in_valid = 1'b1;
                bus.in_x = ops[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0 || 64'(bus.out_q) !== sb[0].q || 64'(bus.out_r) !== sb[0].r ||
                    64'(bus.out_qr) !== sb[0].qr) begin
                    errors++;
                    $display("FAIL round_value idx=%0d q=%0d r=%0d qr=%0d required %0d %0d %0d",
                             got, bus.out_q, bus.out_r, bus.out_qr, sb[0].q, sb[0].r, sb[0].qr);
                end
                got++;
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                sb.push_back(model(64'(bus.in_x), D));
                sent++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL round_count results=%0d required 2", got);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        test_w16();
`ifdef DIVC_ROUND_EN
        test_round();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
